// File: rtl/uf_stage_pkg.sv
// uf_stage_pkg
// Shared definitions for the union-find stage controller: the stage encoding
// that drives the PU array, common widths, and a helper that tells which
// stages belong to an active decoding round.
package uf_stage_pkg;

  localparam int STAGE_WIDTH         = 3;
  localparam int CYCLE_COUNTER_WIDTH = 32;

  typedef enum logic [STAGE_WIDTH-1:0] {
    IDLE                = 3'd0,
    SPREAD_CLUSTER      = 3'd1,
    GROW_BOUNDARY       = 3'd2,
    SYNC_IS_ODD_CLUSTER = 3'd3,
    MEASUREMENT_LOADING = 3'd4,
    RESULT_VALID        = 3'd5,
    DEADLOCK            = 3'd6
  } stage_t;

  // True for every stage of a running round; the terminal and idle stages
  // are the only ones that may accept a new start and freeze the counters.
  function automatic logic is_active(input stage_t s);
    return !(s == IDLE || s == RESULT_VALID || s == DEADLOCK);
  endfunction

endpackage

// File: rtl/uf_quiet_detector.sv
// uf_quiet_detector
// Watches the local and other-side "message flying" flags and raises
// quiet_done in the cycle that completes QUIET_CYCLES consecutive quiet
// cycles. Also carries the optional cross-FPGA synchronizer for the
// other-side status (macro UF_MULTI_FPGA_EN); without it the other side is
// treated as permanently idle and even.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   clear                         forces the quiet count back to zero
//   has_message_flying            local messages in transit
//   has_message_flying_otherside  other-FPGA messages in transit (raw)
//   has_odd_clusters_otherside    other-FPGA odd status (raw)
//   quiet_done                    this cycle is the QUIET_CYCLES-th quiet one
//   odd_otherside                 other-side odd status, ready for use
module uf_quiet_detector #(
  parameter int QUIET_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic has_message_flying,
  input  logic has_message_flying_otherside,
  input  logic has_odd_clusters_otherside,
  output logic quiet_done,
  output logic odd_otherside
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

  logic          flying_other;
  logic          quiet;
  logic [QW-1:0] quiet_count;

`ifdef UF_MULTI_FPGA_EN
  logic [1:0] flying_sync;
  logic [1:0] odd_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flying_sync <= 2'b00;
      odd_sync    <= 2'b00;
    end else begin
      flying_sync <= {flying_sync[0], has_message_flying_otherside};
      odd_sync    <= {odd_sync[0], has_odd_clusters_otherside};
    end
  end

  assign flying_other  = flying_sync[1];
  assign odd_otherside = odd_sync[1];
`else
  logic unused_otherside;
  assign unused_otherside = &{1'b0, has_message_flying_otherside, has_odd_clusters_otherside};
  assign flying_other     = 1'b0;
  assign odd_otherside    = 1'b0;
`endif

  assign quiet      = !has_message_flying && !flying_other;
  assign quiet_done = !clear && quiet && (quiet_count == QUIET_LAST);

  // The count holds at QUIET_LAST; the controller leaves SPREAD on
  // quiet_done, which raises clear and restarts the count from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quiet_count <= '0;
    end else if (clear || !quiet) begin
      quiet_count <= '0;
    end else if (quiet_count != QUIET_LAST) begin
      quiet_count <= quiet_count + 1'b1;
    end
  end

endmodule

// File: rtl/uf_stage_controller.sv
// uf_stage_controller
// Sequences one union-find decoding round: MEASUREMENT_LOADING, then
// repeated SPREAD_CLUSTER / SYNC_IS_ODD_CLUSTER / GROW_BOUNDARY passes until
// no odd cluster is left (RESULT_VALID) or a limit is hit (DEADLOCK).
// Optional macro UF_MULTI_FPGA_EN enables the other-side status inputs
// through a synchronizer and lengthens the sync hold by its latency.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   new_round_start               start pulse, honoured only when not busy
//   has_message_flying(_otherside) messages in transit, local / other FPGA
//   has_odd_clusters(_otherside)  odd-cardinality root, local / other FPGA
//   stage                         current stage encoding to the PU array
//   result_valid, deadlock        round outcome, held until next start
//   iteration_counter             grow iterations in this round
//   cycle_counter                 active cycles since the round started
module uf_stage_controller
  import uf_stage_pkg::*;
#(
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAX_ITERATIONS          = 255,
  parameter int QUIET_CYCLES            = 3,
  parameter int SYNC_CYCLES             = 2,
  parameter int MAX_SPREAD_CYCLES       = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_round_start,
  input  logic                               has_message_flying,
  input  logic                               has_odd_clusters,
  input  logic                               has_message_flying_otherside,
  input  logic                               has_odd_clusters_otherside,
  output logic [STAGE_WIDTH-1:0]             stage,
  output logic                               result_valid,
  output logic                               deadlock,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic [CYCLE_COUNTER_WIDTH-1:0]     cycle_counter
);

`ifdef UF_MULTI_FPGA_EN
  localparam int SYNC_HOLD = SYNC_CYCLES + 2;
`else
  localparam int SYNC_HOLD = SYNC_CYCLES;
`endif

  localparam int SW = $clog2(SYNC_HOLD + 1);
  localparam int WW = $clog2(MAX_SPREAD_CYCLES + 1);
  localparam logic [SW-1:0] SYNC_LAST     = SW'(SYNC_HOLD - 1);
  localparam logic [WW-1:0] WATCHDOG_LAST = WW'(MAX_SPREAD_CYCLES - 1);
  localparam logic [ITERATION_COUNTER_WIDTH-1:0] ITER_LIMIT =
    ITERATION_COUNTER_WIDTH'(MAX_ITERATIONS);

  stage_t        stage_q;
  logic [SW-1:0] sync_count;
  logic [WW-1:0] spread_watchdog;
  logic          quiet_done;
  logic          odd_otherside;
  logic          odd;
  logic          start_accept;

  assign stage        = stage_q;
  assign start_accept = new_round_start && !is_active(stage_q);
  assign odd          = has_odd_clusters || odd_otherside;

  // Holding clear outside SPREAD means every SPREAD visit starts counting
  // quiet cycles from zero.
  uf_quiet_detector #(
    .QUIET_CYCLES(QUIET_CYCLES)
  ) u_quiet_detector (
    .clk                          (clk),
    .reset                        (reset),
    .clear                        (stage_q != SPREAD_CLUSTER),
    .has_message_flying           (has_message_flying),
    .has_message_flying_otherside (has_message_flying_otherside),
    .has_odd_clusters_otherside   (has_odd_clusters_otherside),
    .quiet_done                   (quiet_done),
    .odd_otherside                (odd_otherside)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q           <= IDLE;
      result_valid      <= 1'b0;
      deadlock          <= 1'b0;
      iteration_counter <= '0;
      sync_count        <= '0;
      spread_watchdog   <= '0;
    end else begin
      case (stage_q)
        IDLE, RESULT_VALID, DEADLOCK: begin
          if (start_accept) begin
            stage_q           <= MEASUREMENT_LOADING;
            result_valid      <= 1'b0;
            deadlock          <= 1'b0;
            iteration_counter <= '0;
          end
        end
        MEASUREMENT_LOADING: begin
          stage_q         <= SPREAD_CLUSTER;
          spread_watchdog <= '0;
        end
        // Convergence wins over the watchdog when both land on one cycle.
        SPREAD_CLUSTER: begin
          if (quiet_done) begin
            stage_q    <= SYNC_IS_ODD_CLUSTER;
            sync_count <= '0;
          end else if (spread_watchdog == WATCHDOG_LAST) begin
            stage_q  <= DEADLOCK;
            deadlock <= 1'b1;
          end else begin
            spread_watchdog <= spread_watchdog + 1'b1;
          end
        end
        // Odd status is sampled only in the last hold cycle, after the
        // status of both halves has had time to settle.
        SYNC_IS_ODD_CLUSTER: begin
          if (sync_count == SYNC_LAST) begin
            if (!odd) begin
              stage_q      <= RESULT_VALID;
              result_valid <= 1'b1;
            end else if (iteration_counter == ITER_LIMIT) begin
              stage_q  <= DEADLOCK;
              deadlock <= 1'b1;
            end else begin
              stage_q           <= GROW_BOUNDARY;
              iteration_counter <= iteration_counter + 1'b1;
            end
          end else begin
            sync_count <= sync_count + 1'b1;
          end
        end
        GROW_BOUNDARY: begin
          stage_q         <= SPREAD_CLUSTER;
          spread_watchdog <= '0;
        end
        default: begin
          stage_q <= IDLE;
        end
      endcase
    end
  end

  // A start is only accepted in non-active stages, so clearing and counting
  // never compete for the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_counter <= '0;
    end else if (start_accept) begin
      cycle_counter <= '0;
    end else if (is_active(stage_q) && (cycle_counter != '1)) begin
      cycle_counter <= cycle_counter + 1'b1;
    end
  end

endmodule

// File: tb/tb_uf_stage_controller.sv
// tb_uf_stage_controller
// Self-checking bench for uf_stage_controller (MAX_ITERATIONS=2, other
// parameters at default, UF_MULTI_FPGA_EN undefined).
module tb_uf_stage_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_round_start;
  logic        has_message_flying;
  logic        has_odd_clusters;
  logic        has_message_flying_otherside;
  logic        has_odd_clusters_otherside;
  logic [2:0]  stage;
  logic        result_valid;
  logic        deadlock;
  logic [7:0]  iteration_counter;
  logic [31:0] cycle_counter;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        start;
    logic        flying;
    logic        odd;
    logic [2:0]  stage;
    logic        rv;
    logic        dl;
    logic [7:0]  iter;
    logic [31:0] cyc;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  always #5 clk = ~clk;

  uf_stage_controller #(
    .ITERATION_COUNTER_WIDTH(8),
    .MAX_ITERATIONS(2),
    .QUIET_CYCLES(3),
    .SYNC_CYCLES(2),
    .MAX_SPREAD_CYCLES(1024)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .new_round_start              (new_round_start),
    .has_message_flying           (has_message_flying),
    .has_odd_clusters             (has_odd_clusters),
    .has_message_flying_otherside (has_message_flying_otherside),
    .has_odd_clusters_otherside   (has_odd_clusters_otherside),
    .stage                        (stage),
    .result_valid                 (result_valid),
    .deadlock                     (deadlock),
    .iteration_counter            (iteration_counter),
    .cycle_counter                (cycle_counter)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic start, input logic flying, input logic odd,
                        input int st, input logic rv, input logic dl,
                        input int iter, input int cyc);
    vec_t v;
    v.start = start; v.flying = flying; v.odd = odd;
    v.stage = 3'(st); v.rv = rv; v.dl = dl; v.iter = 8'(iter); v.cyc = 32'(cyc);
    vecs.push_back(v);
  endtask

  // Quiet spread (3 cycles) followed by the two sync cycles; the sync result
  // itself is added by the caller. c is the cycle_counter before the pass.
  task automatic addSpreadSync(input logic odd, input int iter, input int c);
    addVec(0, 0, odd, 1, 0, 0, iter, c + 1);
    addVec(0, 0, odd, 1, 0, 0, iter, c + 2);
    addVec(0, 0, odd, 1, 0, 0, iter, c + 3);
    addVec(0, 0, odd, 3, 0, 0, iter, c + 4);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    new_round_start    = v.start;
    has_message_flying = v.flying;
    has_odd_clusters   = v.odd;
    expq.push_back(v);
  endtask

  task automatic checkVec(input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    e = expq.pop_front();
    checkOutput($sformatf("v%0d.stage", idx), 32'(stage), 32'(e.stage));
    checkOutput($sformatf("v%0d.result_valid", idx), 32'(result_valid), 32'(e.rv));
    checkOutput($sformatf("v%0d.deadlock", idx), 32'(deadlock), 32'(e.dl));
    checkOutput($sformatf("v%0d.iteration", idx), 32'(iteration_counter), 32'(e.iter));
    checkOutput($sformatf("v%0d.cycle", idx), cycle_counter, e.cyc);
  endtask

  initial begin
    reset = 1'b1;
    new_round_start = 1'b0;
    has_message_flying = 1'b0;
    has_odd_clusters = 1'b0;
    has_message_flying_otherside = 1'b0;
    has_odd_clusters_otherside = 1'b0;

    // No syndromes: 4,1,1,1,3,3,5 then frozen.
    addVec(1, 0, 0, 4, 0, 0, 0, 0);
    addSpreadSync(0, 0, 0);
    addVec(0, 0, 0, 3, 0, 0, 0, 5);
    addVec(0, 0, 0, 5, 1, 0, 0, 6);
    addVec(0, 1, 1, 5, 1, 0, 0, 6);

    // Two growth rounds, start in RESULT_VALID clears on the same edge.
    addVec(1, 0, 1, 4, 0, 0, 0, 0);
    addSpreadSync(1, 0, 0);
    addVec(0, 0, 1, 3, 0, 0, 0, 5);
    addVec(0, 0, 1, 2, 0, 0, 1, 6);
    addSpreadSync(1, 1, 6);
    addVec(0, 0, 1, 3, 0, 0, 1, 11);
    addVec(0, 0, 1, 2, 0, 0, 2, 12);
    addSpreadSync(0, 2, 12);
    addVec(0, 0, 0, 3, 0, 0, 2, 17);
    addVec(0, 0, 0, 5, 1, 0, 2, 18);

    // Iteration limit: odd stuck, deadlock at third sync.
    addVec(1, 0, 1, 4, 0, 0, 0, 0);
    addSpreadSync(1, 0, 0);
    addVec(0, 0, 1, 3, 0, 0, 0, 5);
    addVec(0, 0, 1, 2, 0, 0, 1, 6);
    addSpreadSync(1, 1, 6);
    addVec(0, 0, 1, 3, 0, 0, 1, 11);
    addVec(0, 0, 1, 2, 0, 0, 2, 12);
    addSpreadSync(1, 2, 12);
    addVec(0, 0, 1, 3, 0, 0, 2, 17);
    addVec(0, 0, 1, 6, 0, 1, 2, 18);
    addVec(0, 0, 0, 6, 0, 1, 2, 18);

    // Flying glitch at spread cycles 1 and 3, plus an ignored busy start.
    addVec(1, 0, 0, 4, 0, 0, 0, 0);
    addVec(0, 1, 0, 1, 0, 0, 0, 1);
    addVec(1, 0, 0, 1, 0, 0, 0, 2);
    addVec(0, 1, 0, 1, 0, 0, 0, 3);
    addVec(0, 0, 0, 1, 0, 0, 0, 4);
    addVec(0, 0, 0, 1, 0, 0, 0, 5);
    addVec(0, 0, 0, 3, 0, 0, 0, 6);
    addVec(0, 0, 0, 3, 0, 0, 0, 7);
    addVec(0, 0, 0, 5, 1, 0, 0, 8);

    #12;
    checkOutput("reset.stage", 32'(stage), 32'd0);
    checkOutput("reset.result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset.deadlock", 32'(deadlock), 32'd0);
    checkOutput("reset.iteration", 32'(iteration_counter), 32'd0);
    checkOutput("reset.cycle", cycle_counter, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVec(i);
    end

    // Spread watchdog: flying stuck high.
    begin
      int spread_cycles = 0;
      bit reached = 0;
      @(negedge clk);
      new_round_start = 1'b1;
      has_message_flying = 1'b1;
      has_odd_clusters = 1'b1;
      @(negedge clk);
      new_round_start = 1'b0;
      for (int n = 0; n < 1200 && !reached; n++) begin
        @(posedge clk);
        #1;
        if (stage == 3'd1) spread_cycles++;
        if (stage == 3'd6) reached = 1;
      end
      checkOutput("watchdog.reached", 32'(reached), 32'd1);
      checkOutput("watchdog.spread_cycles", 32'(spread_cycles), 32'd1024);
      checkOutput("watchdog.deadlock", 32'(deadlock), 32'd1);
      checkOutput("watchdog.result_valid", 32'(result_valid), 32'd0);
      checkOutput("watchdog.cycle", cycle_counter, 32'd1025);
    end

    // Async reset in the middle of a GROW cycle.
    begin
      bit in_grow = 0;
      @(negedge clk);
      new_round_start = 1'b1;
      has_message_flying = 1'b0;
      has_odd_clusters = 1'b1;
      @(negedge clk);
      new_round_start = 1'b0;
      for (int n = 0; n < 40 && !in_grow; n++) begin
        @(posedge clk);
        #1;
        if (stage == 3'd2) in_grow = 1;
      end
      checkOutput("grow.reached", 32'(in_grow), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset.stage", 32'(stage), 32'd0);
      checkOutput("midreset.result_valid", 32'(result_valid), 32'd0);
      checkOutput("midreset.deadlock", 32'(deadlock), 32'd0);
      checkOutput("midreset.iteration", 32'(iteration_counter), 32'd0);
      checkOutput("midreset.cycle", cycle_counter, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("postreset.stage", 32'(stage), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
